// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - start/result/DUT-vector bundle between sweeper and its surroundings
interface truth_table_sweeper_if #(
  parameter int N_IN = 4
);
  logic                   start;
  logic [(1<<N_IN)-1:0]   exp_tt;
  logic [N_IN-1:0]        abcd;
  logic                   f_in;
  logic                   busy;
  logic                   done;
  logic [(1<<N_IN)-1:0]   tt;
  logic                   match;
  logic [N_IN:0]          mism_cnt;
  logic [N_IN-1:0]        first_mism;

  modport master (
    input  start, exp_tt, f_in,
    output abcd, busy, done, tt, match, mism_cnt, first_mism
  );

  modport slave (
    output start, exp_tt, f_in,
    input  abcd, busy, done, tt, match, mism_cnt, first_mism
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive input sweep of an N-input logic block with truth-table compare
// Optional feature macro: SWEEP_EARLY_STOP_EN (stop the sweep at the first mismatching vector).
module truth_table_sweeper #(
  parameter int N_IN       = 4,
  parameter int SETTLE_CYC = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  truth_table_sweeper_if.master bus
);
  localparam int W  = 1 << N_IN;
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0]   CNT_ONE     = CW'(1);
  localparam logic [N_IN-1:0] VEC_ONE     = N_IN'(1);
  localparam logic [N_IN:0]   MISM_ONE    = (N_IN + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;

  state_t          state;
  logic [N_IN-1:0] vec;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    tt_r;
  logic [N_IN:0]   mism_r;
  logic [N_IN-1:0] first_r;
  logic            busy_r;
  logic            done_r;
  logic            match_r;

  logic            mism;
  logic            last_vec;

  // Current vector disagrees with its expected bit; last vector of the table reached.
  assign mism     = bus.f_in != bus.exp_tt[vec];
  assign last_vec = &vec;

  assign bus.abcd       = vec;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.tt         = tt_r;
  assign bus.match      = match_r;
  assign bus.mism_cnt   = mism_r;
  assign bus.first_mism = first_r;

  // Sweep sequencer: settle each vector, sample f_in, accumulate mismatch statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      vec     <= '0;
      cnt     <= '0;
      tt_r    <= '0;
      mism_r  <= '0;
      first_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      match_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state   <= S_WAIT;
            vec     <= '0;
            cnt     <= SETTLE_LOAD;
            tt_r    <= '0;
            mism_r  <= '0;
            first_r <= '0;
            match_r <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_SAMPLE;
          else           cnt   <= cnt - CNT_ONE;
        end
        S_SAMPLE: begin
          tt_r[vec] <= bus.f_in;
          if (mism) begin
            mism_r <= mism_r + MISM_ONE;
            if (mism_r == '0) first_r <= vec;
          end
`ifdef SWEEP_EARLY_STOP_EN
          if (mism || last_vec) begin
`else
          if (last_vec) begin
`endif
            state <= S_DONE;
          end else begin
            vec   <= vec + VEC_ONE;
            cnt   <= SETTLE_LOAD;
            state <= S_WAIT;
          end
        end
        S_DONE: begin
          done_r  <= 1'b1;
          match_r <= (mism_r == '0);
          busy_r  <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
